// File: rtl/txuart_cfg.sv
// Configurable UART transmitter: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop.
// Define TXUART_PARITY_EN to insert a parity bit (sense chosen by PARITY_ODD).
module txuart_cfg #(
  parameter int CLKS_PER_BAUD = 104,
  parameter int DATA_BITS     = 8,
  parameter int STOP_BITS     = 1,
  parameter int PARITY_ODD    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_in,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx_out,
  output logic                 busy_out
);

  localparam int CW = $clog2(CLKS_PER_BAUD);
  localparam int IW = $clog2(DATA_BITS);

  if (CLKS_PER_BAUD < 2 || CLKS_PER_BAUD > 65535 || DATA_BITS < 5 || DATA_BITS > 8 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("txuart_cfg: illegal parameter value");
  end

`ifdef TXUART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 tx_n, busy_n;
  logic                 baud_end;

`ifdef TXUART_PARITY_EN
  logic par, par_n;
`endif

  assign baud_end = (cnt == CW'(CLKS_PER_BAUD - 1));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    tx_n    = tx_out;
    busy_n  = busy_out;
`ifdef TXUART_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (wr_in) begin
          state_n = START;
          cnt_n   = '0;
          idx_n   = '0;
          shreg_n = data_in;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
`ifdef TXUART_PARITY_EN
          par_n   = (^data_in) ^ 1'(PARITY_ODD);
`endif
        end
      end
      START: begin
        if (baud_end) begin
          state_n = DATA;
          cnt_n   = '0;
          tx_n    = shreg[0];
          shreg_n = shreg >> 1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          cnt_n = '0;
          if (idx == IW'(DATA_BITS - 1)) begin
            idx_n = '0;
`ifdef TXUART_PARITY_EN
            state_n = PARITY;
            tx_n    = par;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            idx_n   = idx + IW'(1);
            tx_n    = shreg[0];
            shreg_n = shreg >> 1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`ifdef TXUART_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          state_n = STOP;
          cnt_n   = '0;
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          cnt_n = '0;
          if (idx == IW'(STOP_BITS - 1)) begin
            // line already high; dropping busy here gives the single idle cycle
            state_n = IDLE;
            idx_n   = '0;
            busy_n  = 1'b0;
          end else begin
            idx_n = idx + IW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      tx_out   <= 1'b1;
      busy_out <= 1'b0;
`ifdef TXUART_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shreg    <= shreg_n;
      tx_out   <= tx_n;
      busy_out <= busy_n;
`ifdef TXUART_PARITY_EN
      par      <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_txuart_cfg.sv
// Bench for txuart_cfg: frame-level model per instance plus directed literal checks.
module tb_txuart_cfg;

`ifdef TXUART_PARITY_EN
  localparam int P = 1;
  localparam logic [10:0] EXP_A = 11'h54A;  // 0xA5 8E1
  localparam logic [10:0] EXP_B = 11'h1A6;  // 0x13 5O2
`else
  localparam int P = 0;
  localparam logic [10:0] EXP_A = 11'h34A;  // 0xA5 8N1
  localparam logic [10:0] EXP_B = 11'h0E6;  // 0x13 5N2
`endif
  localparam int CA = 4, NA = 10 + P;
  localparam int CB = 3, NB = 8 + P;

  logic clk = 1'b0, rst = 1'b1;
  logic wr_a = 1'b0, wr_b = 1'b0;
  logic [7:0] din_a = '0;
  logic [4:0] din_b = '0;
  logic tx_a, busy_a, tx_b, busy_b;
  int vectors = 0, miscompares = 0;
  bit en = 1'b0;

  always #5 clk = ~clk;

  txuart_cfg #(.CLKS_PER_BAUD(CA), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
    .clk(clk), .rst(rst), .wr_in(wr_a), .data_in(din_a), .tx_out(tx_a), .busy_out(busy_a));
  txuart_cfg #(.CLKS_PER_BAUD(CB), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(1)) u_b (
    .clk(clk), .rst(rst), .wr_in(wr_b), .data_in(din_b), .tx_out(tx_b), .busy_out(busy_b));

  task automatic chk(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Line bit b of a frame: start, data LSB first, optional parity, then stop ones.
  function automatic logic fbit(input logic [7:0] d, input int b, input int db, input bit odd);
    logic [7:0] m;
    m = d & 8'((1 << db) - 1);
    if (b == 0) return 1'b0;
    if (b <= db) return d[b-1];
    if (P == 1 && b == db + 1) return (^m) ^ odd;
    return 1'b1;
  endfunction

  // Frame model: cycle k of an accepted frame shows bit k/C; idle shows line high.
  logic ma_act = 1'b0, mb_act = 1'b0;
  int ma_k = 0, mb_k = 0;
  logic [7:0] ma_d = '0, mb_d = '0;

  always @(posedge clk) begin
    if (rst) ma_act <= 1'b0;
    else if (ma_act) begin
      if (ma_k + 1 == NA * CA) ma_act <= 1'b0;
      ma_k <= ma_k + 1;
    end else if (wr_a) begin
      ma_act <= 1'b1; ma_k <= 0; ma_d <= din_a;
    end
    if (rst) mb_act <= 1'b0;
    else if (mb_act) begin
      if (mb_k + 1 == NB * CB) mb_act <= 1'b0;
      mb_k <= mb_k + 1;
    end else if (wr_b) begin
      mb_act <= 1'b1; mb_k <= 0; mb_d <= {3'b000, din_b};
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("model_a_busy", busy_a, ma_act);
      chk("model_a_tx", tx_a, ma_act ? fbit(ma_d, ma_k / CA, 8, 1'b0) : 1'b1);
      chk("model_b_busy", busy_b, mb_act);
      chk("model_b_tx", tx_b, mb_act ? fbit(mb_d, mb_k / CB, 5, 1'b1) : 1'b1);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic lit_frame(input string nm, input bit sel, input logic [7:0] d,
                           input logic [10:0] exp, input int nb, input int c);
    if (sel) begin wr_b = 1'b1; din_b = d[4:0]; end
    else begin wr_a = 1'b1; din_a = d; end
    tick;
    wr_a = 1'b0; wr_b = 1'b0;
    for (int i = 0; i < nb * c; i++) begin
      @(negedge clk);
      chk({nm, "_tx"}, sel ? tx_b : tx_a, exp[i / c]);
      chk({nm, "_busy"}, sel ? busy_b : busy_a, 1'b1);
    end
    @(negedge clk);
    chk({nm, "_end_busy"}, sel ? busy_b : busy_a, 1'b0);
    chk({nm, "_end_tx"}, sel ? tx_b : tx_a, 1'b1);
  endtask

  initial begin
    bit seq [200];
    int busycnt, p, run1, gap, run2;

    tick; tick;
    en = 1'b1;
    chk("reset_tx_a", tx_a, 1'b1);
    chk("reset_busy_a", busy_a, 1'b0);
    chk("reset_tx_b", tx_b, 1'b1);
    chk("reset_busy_b", busy_b, 1'b0);
    rst = 1'b0;
    tick;

    // basic frames on both configurations
    lit_frame("a5_frame", 1'b0, 8'hA5, EXP_A, NA, CA);
    repeat (3) tick;
    lit_frame("b13_frame", 1'b1, 8'h13, EXP_B, NB, CB);
    repeat (3) tick;

    // writes and data changes during a frame are ignored
    din_a = 8'hA5; wr_a = 1'b1;
    tick;
    wr_a = 1'b0;
    busycnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      busycnt += int'(busy_a);
      if (i == 1) din_a = 8'h00;
      if (i == 10) wr_a = 1'b1;
      if (i == 11) wr_a = 1'b0;
    end
    chki("ignore_wr_busy_len", busycnt, NA * CA);
    tick;

    // mid-frame reset, with wr_in held during reset
    din_a = 8'hA5; wr_a = 1'b1;
    tick;
    wr_a = 1'b0;
    repeat (16) tick;
    rst = 1'b1; wr_a = 1'b1;
    tick;
    chk("midrst_tx", tx_a, 1'b1);
    chk("midrst_busy", busy_a, 1'b0);
    tick;
    rst = 1'b0; wr_a = 1'b0;
    tick;
    chk("rst_wr_ignored_busy", busy_a, 1'b0);
    lit_frame("after_rst", 1'b0, 8'hA5, EXP_A, NA, CA);
    repeat (2) tick;

    // back-to-back frames with wr_in held high
    din_a = 8'h55; wr_a = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      seq[i] = busy_a;
    end
    wr_a = 1'b0;
    p = 0; run1 = 0; gap = 0; run2 = 0;
    while (p < 150 && !seq[p]) p++;
    while (p < 150 && seq[p]) begin run1++; p++; end
    while (p < 150 && !seq[p]) begin gap++; p++; end
    while (p < 150 && seq[p]) begin run2++; p++; end
    chki("b2b_run1", run1, NA * CA);
    chki("b2b_gap", gap, 1);
    chki("b2b_run2", run2, NA * CA);
    repeat (NA * CA + 5) tick;
    chk("b2b_drain_busy", busy_a, 1'b0);
    chk("b2b_drain_tx", tx_a, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
